// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register: operating mode encodings.
package universal_shift_register_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle of the universal shift register.
// master = the side that drives mode/data requests, slave = the register itself.
interface universal_shift_register_if #(
    parameter int WIDTH = 8
);
    import universal_shift_register_pkg::*;

    mode_e             mode;
    logic              rotate;
    logic              serial_in;
    logic [WIDTH-1:0]  load_data;
    logic              step;
    logic [WIDTH-1:0]  data_out;
    logic              serial_out;
    logic              strobe;
    logic              word_done;

    modport master (
        output mode, rotate, serial_in, load_data, step,
        input  data_out, serial_out, strobe, word_done
    );

    modport slave (
        input  mode, rotate, serial_in, load_data, step,
        output data_out, serial_out, strobe, word_done
    );

endinterface

// File: rtl/universal_shift_register_strobe_gen.sv
// Free-running divider: one-cycle strobe every 2^DIV_WIDTH clocks,
// high in the first cycle after reset is released.
module strobe_gen #(
    parameter int DIV_WIDTH = 22
) (
    input  logic clock,
    input  logic reset,
    output logic strobe
);

    logic [DIV_WIDTH-1:0] div_cnt;

    // Wrapping divider counter, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    assign strobe = (div_cnt == '0);

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with optional rotation, a bit counter and a one-cycle word_done pulse after
// every WIDTH shifts. Shifts are paced by the internal strobe or by step.
module universal_shift_register
    import universal_shift_register_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 22,
    parameter int USE_TIMER = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    universal_shift_register_if.slave   bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic              strobe_w;
    logic              advance;
    logic              in_bit;
    logic              shift_en;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    generate
        if (USE_TIMER != 0) begin : g_timer
            strobe_gen #(
                .DIV_WIDTH (DIV_WIDTH)
            ) u_strobe_gen (
                .clock  (clock),
                .reset  (reset),
                .strobe (strobe_w)
            );
        end else begin : g_no_timer
            assign strobe_w = 1'b0;
        end
    endgenerate

    assign advance = (USE_TIMER != 0) ? strobe_w : bus.step;

    // Next-state: shift/load data, count executed shifts, flag word completion.
    always_comb begin
        data_d   = data_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        in_bit   = bus.serial_in;
        shift_en = 1'b0;
        case (bus.mode)
            MODE_RIGHT: begin
                if (advance) begin
                    in_bit   = bus.rotate ? data_q[0] : bus.serial_in;
                    data_d   = {in_bit, data_q[WIDTH-1:1]};
                    shift_en = 1'b1;
                end
            end
            MODE_LEFT: begin
                if (advance) begin
                    in_bit   = bus.rotate ? data_q[WIDTH-1] : bus.serial_in;
                    data_d   = {data_q[WIDTH-2:0], in_bit};
                    shift_en = 1'b1;
                end
            end
            MODE_LOAD: begin
                data_d = bus.load_data;
                cnt_d  = '0;
            end
            default: ;
        endcase
        // Shifts in either direction share one count so a direction change
        // mid-word does not restart the word.
        if (shift_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.word_done  = done_q;
    assign bus.strobe     = strobe_w;
    assign bus.serial_out = (bus.mode == MODE_LEFT) ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register: a step-paced
// instance (USE_TIMER=0) and a fast-timer instance (DIV_WIDTH=3, USE_TIMER=1).
module tb_universal_shift_register;
    import universal_shift_register_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    universal_shift_register_if #(.WIDTH(8)) bus_a ();
    universal_shift_register_if #(.WIDTH(8)) bus_b ();

    universal_shift_register #(
        .WIDTH     (8),
        .DIV_WIDTH (22),
        .USE_TIMER (0)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    universal_shift_register #(
        .WIDTH     (8),
        .DIV_WIDTH (3),
        .USE_TIMER (1)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] exp_right [8] = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
    logic [7:0] exp_rot   [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    logic [7:0] exp_fill  [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] exp_timer [4] = '{8'h00, 8'h80, 8'hC0, 8'hE0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one set of inputs to the step-paced instance and let one edge pass.
    task automatic tick(input mode_e m, input logic st, input logic si,
                        input logic rot, input logic [7:0] ld);
        bus_a.mode      = m;
        bus_a.step      = st;
        bus_a.serial_in = si;
        bus_a.rotate    = rot;
        bus_a.load_data = ld;
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] e;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus_a.mode = MODE_HOLD;  bus_a.step = 1'b0; bus_a.serial_in = 1'b0;
        bus_a.rotate = 1'b0;     bus_a.load_data = 8'h00;
        bus_b.mode = MODE_RIGHT; bus_b.step = 1'b1; bus_b.serial_in = 1'b1;
        bus_b.rotate = 1'b0;     bus_b.load_data = 8'h00;
        repeat (2) @(negedge clock);

        check("reset_data_a", 32'(bus_a.data_out), 32'h00);
        check("reset_done_a", 32'(bus_a.word_done), 32'h0);
        check("reset_sout_a", 32'(bus_a.serial_out), 32'h0);
        check("reset_data_b", 32'(bus_b.data_out), 32'h00);
        check("strobe_tied_a", 32'(bus_a.strobe), 32'h0);

        // Timer-paced instance: strobe on cycles 0,8,16,24; step held high throughout.
        reset = 1'b0;
        for (int unsigned c = 0; c < 25; c++) begin
            #1;
            check("timer_strobe", 32'(bus_b.strobe), (c % 8 == 0) ? 32'h1 : 32'h0);
            check("timer_data", 32'(bus_b.data_out), 32'(exp_timer[(c + 7) / 8]));
            @(negedge clock);
        end

        // Load A5, then shift right 8 times with zeros in.
        tick(MODE_LOAD, 1'b0, 1'b0, 1'b0, 8'hA5);
        check("load_a5", 32'(bus_a.data_out), 32'hA5);
        for (int unsigned i = 0; i < 8; i++) begin
            tick(MODE_RIGHT, 1'b1, 1'b0, 1'b0, 8'h00);
            e = exp_right[i];
            check("shr_data", 32'(bus_a.data_out), 32'(e));
            check("shr_sout", 32'(bus_a.serial_out), 32'(e[0]));
            check("shr_done", 32'(bus_a.word_done), (i == 7) ? 32'h1 : 32'h0);
        end
        tick(MODE_HOLD, 1'b0, 1'b0, 1'b0, 8'h00);
        check("done_selfclear", 32'(bus_a.word_done), 32'h0);

        // Rotate left from 81: eight rotations bring the word back.
        tick(MODE_LOAD, 1'b0, 1'b0, 1'b0, 8'h81);
        check("load_81", 32'(bus_a.data_out), 32'h81);
        for (int unsigned i = 0; i < 8; i++) begin
            tick(MODE_LEFT, 1'b1, 1'b0, 1'b1, 8'h00);
            e = exp_rot[i];
            check("rotl_data", 32'(bus_a.data_out), 32'(e));
            check("rotl_sout", 32'(bus_a.serial_out), 32'(e[7]));
            check("rotl_done", 32'(bus_a.word_done), (i == 7) ? 32'h1 : 32'h0);
        end

        // Five shifts, reload, then a full word: only the 8th post-load shift completes.
        for (int unsigned i = 0; i < 5; i++) begin
            tick(MODE_RIGHT, 1'b1, 1'b0, 1'b0, 8'h00);
            check("pre_load_done", 32'(bus_a.word_done), 32'h0);
        end
        tick(MODE_LOAD, 1'b1, 1'b0, 1'b0, 8'hFF);
        check("midload_data", 32'(bus_a.data_out), 32'hFF);
        check("midload_done", 32'(bus_a.word_done), 32'h0);
        for (int unsigned i = 0; i < 8; i++) begin
            tick((i % 2 == 0) ? MODE_RIGHT : MODE_LEFT, 1'b1, 1'b1, 1'b0, 8'h00);
            check("postload_data", 32'(bus_a.data_out), 32'hFF);
            check("postload_done", 32'(bus_a.word_done), (i == 7) ? 32'h1 : 32'h0);
        end

        // Build 3C with three counted shifts, then reset mid-word.
        tick(MODE_LOAD, 1'b0, 1'b0, 1'b0, 8'hE0);
        tick(MODE_RIGHT, 1'b1, 1'b1, 1'b0, 8'h00);
        tick(MODE_RIGHT, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(MODE_RIGHT, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pre_reset_3c", 32'(bus_a.data_out), 32'h3C);
        reset = 1'b1;
        tick(MODE_RIGHT, 1'b1, 1'b1, 1'b0, 8'h00);
        check("midreset_data", 32'(bus_a.data_out), 32'h00);
        check("midreset_done", 32'(bus_a.word_done), 32'h0);
        check("midreset_sout", 32'(bus_a.serial_out), 32'h0);
        reset = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            tick(MODE_RIGHT, 1'b1, 1'b1, 1'b0, 8'h00);
            check("postreset_data", 32'(bus_a.data_out), 32'(exp_fill[i]));
            check("postreset_done", 32'(bus_a.word_done), (i == 7) ? 32'h1 : 32'h0);
        end

        // Load with step low, then hold with step high, then shift modes without step.
        tick(MODE_LOAD, 1'b0, 1'b0, 1'b0, 8'h96);
        check("load_nostep", 32'(bus_a.data_out), 32'h96);
        for (int unsigned i = 0; i < 10; i++) begin
            tick(MODE_HOLD, 1'b1, 1'b1, 1'b0, 8'h00);
            check("hold_data", 32'(bus_a.data_out), 32'h96);
            check("hold_sout", 32'(bus_a.serial_out), 32'h0);
            check("hold_done", 32'(bus_a.word_done), 32'h0);
        end
        tick(MODE_LEFT, 1'b0, 1'b1, 1'b0, 8'h00);
        check("left_nostep_data", 32'(bus_a.data_out), 32'h96);
        check("left_sout_msb", 32'(bus_a.serial_out), 32'h1);
        tick(MODE_RIGHT, 1'b0, 1'b1, 1'b0, 8'h00);
        check("right_nostep_data", 32'(bus_a.data_out), 32'h96);
        check("right_sout_lsb", 32'(bus_a.serial_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter DIV_WIDTH, default 22, strobe divider width; strobe period is 2^DIV_WIDTH clocks (~0.35 s at 12 MHz for 22).
REQ-003 Parameter USE_TIMER, default 1; 1 = shifts paced by the internal strobe, 0 = shifts paced by the external step input.
REQ-004 clock  input  1  system clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 rotate  input  1  1 = recirculate the outgoing bit instead of taking serial_in.
REQ-008 serial_in  input  1  serial data entering the register.
REQ-009 load_data  input  WIDTH  parallel load value.
REQ-010 step  input  1  external advance request; ignored when USE_TIMER=1.
REQ-011 data_out  output  WIDTH  register contents, registered.
REQ-012 serial_out  output  1  bit at the exit end, combinational from data_out.
REQ-013 strobe  output  1  divider tick, high one cycle per period.
REQ-014 word_done  output  1  registered one-cycle pulse after WIDTH shifts.

Function
REQ-015 advance SHALL equal strobe when USE_TIMER=1, and step otherwise.
REQ-016 Divider: a DIV_WIDTH-bit counter increments every cycle and wraps; strobe SHALL be high exactly when the counter is 0.
REQ-017 Mode 01 with advance: data_out <= {in_bit, data_out[WIDTH-1:1]}; in_bit = rotate ? data_out[0] : serial_in.
REQ-018 Mode 10 with advance: data_out <= {data_out[WIDTH-2:0], in_bit}; in_bit = rotate ? data_out[WIDTH-1] : serial_in.
REQ-019 Mode 11: data_out <= load_data in any cycle, regardless of advance.
REQ-020 Mode 00, or mode 01/10 without advance: data_out, bit count and word_done state SHALL be unchanged, except word_done self-clears.
REQ-021 serial_out SHALL be data_out[WIDTH-1] in mode 10, and data_out[0] in every other mode.
REQ-022 Bit counter, $clog2(WIDTH) bits: increments on each executed shift; on the shift where it equals WIDTH-1 it wraps to 0 and word_done is asserted in the next cycle for exactly one cycle.
REQ-023 Parallel load SHALL clear the bit counter and force word_done to 0 in the next cycle.
REQ-024 Changing between modes 01 and 10 mid-word SHALL NOT clear the bit counter; shifts in both directions count.
REQ-025 rotate SHALL NOT affect counting or word_done.
REQ-026 Latency: a shift or load is visible on data_out one clock after the qualifying edge; there is no pipelining.

Reset
REQ-027 reset SHALL take priority over every other input.
REQ-028 While reset is asserted, data_out, the bit counter, the divider counter and word_done SHALL all clear to 0.
REQ-029 After reset is released, strobe SHALL be high in the first cycle, and then every 2^DIV_WIDTH cycles.
REQ-030 Reset asserted mid-word SHALL discard the partial count; no word_done pulse is issued for it.

Structure
REQ-031 A shared package SHALL hold the mode encodings MODE_HOLD, MODE_RIGHT, MODE_LEFT and MODE_LOAD.
REQ-032 The divider SHALL be a sub-module strobe_gen, parameter DIV_WIDTH, with ports clock, reset and strobe; it is instantiated only when USE_TIMER=1, and strobe is tied to 0 otherwise.

Verification
REQ-033 USE_TIMER=0, WIDTH=8: load 8'hA5, then mode 01, serial_in=0, 8 steps -> data_out 52,29,14,0A,05,02,01,00; word_done pulses once, the cycle after the 8th step.
REQ-034 Rotate: load 8'h81, mode 10, rotate=1, 1 step -> 8'h03; after 8 steps total -> 8'h81 and word_done pulses.
REQ-035 Load mid-word: 5 shifts, then load 8'hFF, then 8 shifts -> word_done pulses only after the 8th post-load shift.
REQ-036 DIV_WIDTH=3, USE_TIMER=1, mode 01, serial_in=1, from reset -> strobe high on cycles 0,8,16,...; data_out 80,C0,E0 updates only in those cycles; step is ignored.
REQ-037 Reset asserted with data_out=8'h3C and 3 shifts counted -> all outputs 0 in the next cycle; a subsequent 8 shifts give exactly one word_done.
REQ-038 Mode 00 with step high for 10 cycles -> data_out, serial_out and word_done are unchanged; mode 11 with step low -> load still occurs.
